mm_bus_responder: RTL and testbench

//   Main-memory-side responder for the dual-core bus. Accepts read/write

---
 rtl/mm_bus_responder.sv | 136 +++++++++++++
 tb/tb_mm_bus_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mm_bus_responder.sv
// Main-memory responder for the dual-core bus: arbitrates A/B requests, snoops the
// other core, absorbs a modified-line write-back, accesses memory and returns DR.
module mm_bus_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_W     = 32,
  parameter int WB_TIMEOUT = 15
) (
  input  logic              SCLK,
  input  logic              SRST,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              RW_A,
  input  logic              RW_B,
  input  logic [23:0]       ADDR_A,
  input  logic [23:0]       ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  input  logic              PHITM_A,
  input  logic              PHITM_B,
  input  logic              WB_VALID,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              SNOOP_A,
  output logic              SNOOP_B,
  output logic [23:0]       SNOOP_ADDR,
  output logic              DR_A,
  output logic              DR_B,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              ERR
);

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] TO_LIM = 4'(WB_TIMEOUT);

  typedef enum logic [2:0] {IDLE, SNOOP, CHECK, WAIT_WB, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic                  grant, grant_nxt;   // 0 = core A, 1 = core B
  logic                  last_grant;
  logic                  req_rw;
  logic [DATA_W-1:0]     req_wdata;
  logic [3:0]            wb_cnt;
  logic                  timeout;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [ADDR_BITS-1:0]  idx;
  logic                  accept;
  logic [DATA_W-1:0]     mem [DEPTH];

  // SNOOP_ADDR doubles as the latched request address; upper bits alias.
  assign idx    = SNOOP_ADDR[ADDR_BITS-1:0];
  assign accept = (state == IDLE) && (REQ_A || REQ_B);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    mem_we    = 1'b0;
    mem_wdata = req_wdata;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          grant_nxt = (REQ_A && REQ_B) ? ~last_grant : REQ_B;
          state_nxt = SNOOP;
        end
      end
      SNOOP: state_nxt = CHECK;
      CHECK: state_nxt = (grant ? PHITM_A : PHITM_B) ? WAIT_WB : ACCESS;
      WAIT_WB: begin
        if (WB_VALID) begin
          mem_we    = 1'b1;
          mem_wdata = WB_DATA;
          state_nxt = ACCESS;
        end else if (wb_cnt + 4'd1 == TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = req_rw;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign SNOOP_A = (state == SNOOP) &&  grant;
  assign SNOOP_B = (state == SNOOP) && !grant;
  assign DR_A    = (state == DONE)  && !grant;
  assign DR_B    = (state == DONE)  &&  grant;
  assign BUSY    = (state != IDLE);

  always_ff @(posedge SCLK) begin
    if (!SRST) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      req_rw     <= 1'b0;
      wb_cnt     <= 4'd0;
      ERR        <= 1'b0;
      RDATA      <= '0;
      SNOOP_ADDR <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (accept) begin
        SNOOP_ADDR <= grant_nxt ? ADDR_B : ADDR_A;
        req_rw     <= grant_nxt ? RW_B : RW_A;
      end
      if (state == CHECK)
        wb_cnt <= 4'd0;
      else if (state == WAIT_WB && !WB_VALID && !timeout)
        wb_cnt <= wb_cnt + 4'd1;
      if (timeout)
        ERR <= 1'b1;
      if (state == ACCESS) begin
        last_grant <= grant;
        if (!req_rw)
          RDATA <= mem[idx];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (accept)
      req_wdata <= grant_nxt ? WDATA_B : WDATA_A;
  end

  // A reset edge suppresses any pending memory write.
  always_ff @(posedge SCLK) begin
    if (SRST && mem_we)
      mem[idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_mm_bus_responder.sv
// Directed bench for mm_bus_responder: latency, arbitration, write-back,
// timeout, mid-transaction reset and address aliasing.
module tb_mm_bus_responder;

  logic        SCLK = 1'b0;
  logic        SRST;
  logic        REQ_A, REQ_B, RW_A, RW_B;
  logic [23:0] ADDR_A, ADDR_B;
  logic [31:0] WDATA_A, WDATA_B;
  logic        PHITM_A, PHITM_B, WB_VALID;
  logic [31:0] WB_DATA;
  logic        SNOOP_A, SNOOP_B, DR_A, DR_B, BUSY, ERR;
  logic [23:0] SNOOP_ADDR;
  logic [31:0] RDATA;

  int n_checks = 0;
  int n_errors = 0;

  int          snp_cyc, dr_cyc;
  logic [1:0]  snp_ab, dr_ab;
  logic [23:0] snp_addr;
  logic [31:0] rd_v;

  mm_bus_responder #(.ADDR_BITS(10), .DATA_W(32), .WB_TIMEOUT(15)) dut (
    .SCLK(SCLK), .SRST(SRST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .RW_A(RW_A), .RW_B(RW_B),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
    .PHITM_A(PHITM_A), .PHITM_B(PHITM_B), .WB_VALID(WB_VALID), .WB_DATA(WB_DATA),
    .SNOOP_A(SNOOP_A), .SNOOP_B(SNOOP_B), .SNOOP_ADDR(SNOOP_ADDR),
    .DR_A(DR_A), .DR_B(DR_B), .RDATA(RDATA), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 SCLK = ~SCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic core, input logic rw, input logic [23:0] addr,
                       input logic [31:0] d);
    if (!core) begin
      REQ_A = 1'b1; RW_A = rw; ADDR_A = addr; WDATA_A = d;
    end else begin
      REQ_B = 1'b1; RW_B = rw; ADDR_B = addr; WDATA_B = d;
    end
  endtask

  // Called at a negedge in the IDLE cycle that samples the request (cycle 0).
  // Returns at the negedge of the following IDLE cycle.
  task automatic wait_dr(input int wbc, input logic [31:0] wbd);
    snp_cyc = -1; dr_cyc = -1;
    snp_ab = 2'b00; dr_ab = 2'b00; snp_addr = '0; rd_v = '0;
    for (int c = 1; c <= 60 && dr_cyc < 0; c++) begin
      @(negedge SCLK);
      if (c == wbc) begin
        WB_VALID = 1'b1; WB_DATA = wbd;
      end else begin
        WB_VALID = 1'b0;
      end
      if ((SNOOP_A || SNOOP_B) && snp_cyc < 0) begin
        snp_cyc = c; snp_ab = {SNOOP_A, SNOOP_B}; snp_addr = SNOOP_ADDR;
      end
      if (DR_A || DR_B) begin
        dr_cyc = c; dr_ab = {DR_A, DR_B}; rd_v = RDATA;
        if (DR_A) REQ_A = 1'b0;
        if (DR_B) REQ_B = 1'b0;
      end
    end
    if (dr_cyc < 0) check_eq("dr_timeout", 32'd0, 32'd1);
    @(negedge SCLK);
    WB_VALID = 1'b0;
    check_eq("dr_one_cycle", {30'd0, DR_A, DR_B}, 32'd0);
    check_eq("idle_after_done", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    SRST = 1'b0; REQ_A = 0; REQ_B = 0; RW_A = 0; RW_B = 0;
    ADDR_A = '0; ADDR_B = '0; WDATA_A = '0; WDATA_B = '0;
    PHITM_A = 0; PHITM_B = 0; WB_VALID = 0; WB_DATA = '0;
    repeat (3) @(negedge SCLK);
    check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rst_dr", {30'd0, DR_A, DR_B}, 32'd0);
    check_eq("rst_snoop", {30'd0, SNOOP_A, SNOOP_B}, 32'd0);
    check_eq("rst_err", {31'd0, ERR}, 32'd0);
    check_eq("rst_rdata", RDATA, 32'd0);
    check_eq("rst_snoop_addr", {8'd0, SNOOP_ADDR}, 32'd0);
    SRST = 1'b1;
    @(negedge SCLK);

    // Test 1: A write (own PHITM_A must be ignored), then B read back
    PHITM_A = 1'b1;
    issue(1'b0, 1'b1, 24'h000010, 32'hDEADBEEF);
    wait_dr(-1, 32'h0);
    PHITM_A = 1'b0;
    check_eq("t1w_snoop_cyc", snp_cyc, 32'd1);
    check_eq("t1w_snoop_b", {30'd0, snp_ab}, 32'b01);
    check_eq("t1w_snoop_addr", {8'd0, snp_addr}, 32'h10);
    check_eq("t1w_dr_cyc", dr_cyc, 32'd4);
    check_eq("t1w_dr_a", {30'd0, dr_ab}, 32'b10);
    check_eq("t1w_rdata_untouched", rd_v, 32'd0);
    issue(1'b1, 1'b0, 24'h000010, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t1r_snoop_a", {30'd0, snp_ab}, 32'b10);
    check_eq("t1r_dr_cyc", dr_cyc, 32'd4);
    check_eq("t1r_dr_b", {30'd0, dr_ab}, 32'b01);
    check_eq("t1r_rdata", rd_v, 32'hDEADBEEF);

    // Test 2: simultaneous requests after reset, then alternation
    SRST = 1'b0;
    @(negedge SCLK);
    SRST = 1'b1;
    @(negedge SCLK);
    issue(1'b0, 1'b0, 24'h000010, 32'h0);
    issue(1'b1, 1'b0, 24'h000030, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t2_first_a", {30'd0, dr_ab}, 32'b10);
    check_eq("t2_first_rdata", rd_v, 32'hDEADBEEF);
    wait_dr(-1, 32'h0);
    check_eq("t2_second_b", {30'd0, dr_ab}, 32'b01);
    check_eq("t2_second_cyc", dr_cyc, 32'd4);
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_dr(-1, 32'h0);
      check_eq($sformatf("t2_alt%0d", i), {30'd0, dr_ab}, (i % 2 == 0) ? 32'b10 : 32'b01);
      REQ_A = 1'b1; REQ_B = 1'b1;
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    @(negedge SCLK);

    // Test 3: A read with modified hit in B, write-back 3 cycles into WAIT_WB
    PHITM_B = 1'b1;
    issue(1'b0, 1'b0, 24'h000020, 32'h0);
    wait_dr(6, 32'h12345678);
    PHITM_B = 1'b0;
    check_eq("t3_dr_cyc", dr_cyc, 32'd8);
    check_eq("t3_dr_a", {30'd0, dr_ab}, 32'b10);
    check_eq("t3_rdata", rd_v, 32'h12345678);
    check_eq("t3_err", {31'd0, ERR}, 32'd0);
    issue(1'b1, 1'b0, 24'h000020, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t3_mem", rd_v, 32'h12345678);

    // Test 4: B read with modified hit in A, write-back never arrives
    WB_DATA = 32'hBADBAD00;
    PHITM_A = 1'b1;
    issue(1'b1, 1'b0, 24'h000020, 32'h0);
    wait_dr(-1, 32'h0);
    PHITM_A = 1'b0;
    check_eq("t4_dr_cyc", dr_cyc, 32'd19);
    check_eq("t4_dr_b", {30'd0, dr_ab}, 32'b01);
    check_eq("t4_err", {31'd0, ERR}, 32'd1);
    check_eq("t4_mem_unchanged", rd_v, 32'h12345678);
    issue(1'b0, 1'b0, 24'h000020, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t4_err_sticky", {31'd0, ERR}, 32'd1);

    // Test 5: reset during WAIT_WB with a write-back arriving on the reset edge
    PHITM_B = 1'b1;
    issue(1'b0, 1'b1, 24'h400010, 32'hCAFEF00D);
    for (int c = 1; c <= 5; c++) @(negedge SCLK);
    check_eq("t5_busy_in_wait", {31'd0, BUSY}, 32'd1);
    SRST = 1'b0; WB_VALID = 1'b1; WB_DATA = 32'h0BADF00D; REQ_A = 1'b0;
    @(negedge SCLK);
    check_eq("t5_busy", {31'd0, BUSY}, 32'd0);
    check_eq("t5_dr", {30'd0, DR_A, DR_B}, 32'd0);
    check_eq("t5_snoop", {30'd0, SNOOP_A, SNOOP_B}, 32'd0);
    check_eq("t5_err", {31'd0, ERR}, 32'd0);
    check_eq("t5_rdata", RDATA, 32'd0);
    check_eq("t5_snoop_addr", {8'd0, SNOOP_ADDR}, 32'd0);
    SRST = 1'b1; WB_VALID = 1'b0; PHITM_B = 1'b0;
    @(negedge SCLK);
    check_eq("t5_no_dr_after", {30'd0, DR_A, DR_B}, 32'd0);
    issue(1'b1, 1'b0, 24'h000010, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t5_no_mem_write", rd_v, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 24'h400010, 32'hA5A55A5A);
    wait_dr(-1, 32'h0);
    check_eq("t5_alias_snoop_addr", {8'd0, snp_addr}, 32'h400010);
    issue(1'b1, 1'b0, 24'h000010, 32'h0);
    wait_dr(-1, 32'h0);
    check_eq("t5_alias_read", rd_v, 32'hA5A55A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
